pll_rst_seq: RTL
================

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 64: PLL reset pulse length in clkin cycles (>=2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles to wait for lock before a retry.
REQ-003 SHALL have parameter LOCK_STABLE, default 256: cycles of continuous synchronized lock required before enabling clocks.
REQ-004 SHALL have parameter EN_GAP, default 16: cycles between successive clock-enable steps.
REQ-005 SHALL have parameter MAX_RETRY, default 7: lock timeouts allowed before failing (<=7).
REQ-006 SHALL have port clkin, input, 1: 50 MHz reference clock, the same net that feeds the PLL; the only clock.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port pll_lock, input, 1: PLL lock, asynchronous to clkin.
REQ-009 SHALL have port pll_reset, output, 1: drives the PLL reset input.
REQ-010 SHALL have port pll_enclk, output, 3: drives PLL enclk2..0 (bit n = enclkn).
REQ-011 SHALL have port sys_rst, output, 1: active-high reset for the logic clocked by the PLL outputs.
REQ-012 SHALL have ports ready (1), fail (1), retry_cnt (3) and lock_lost (1), all outputs: status.

Function
REQ-013 SHALL synchronize pll_lock through two clkin flops (lock_s); all decisions use lock_s only.
REQ-014 SHALL use states RST, WAIT_LOCK, STABLE, EN0, EN1, EN2, RUN, FAIL, plus one shared cycle counter cnt that clears on every state change.
REQ-015 SHALL register all outputs, decoded from next-state, so each output changes on the same edge as the state.
REQ-016 RST: pll_reset=1; after RST_CYCLES cycles in RST -> WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_reset=0; lock_s=1 -> STABLE; after LOCK_TIMEOUT cycles without lock_s -> RST with retry_cnt+1, or -> FAIL if retry_cnt==MAX_RETRY.
REQ-018 STABLE: lock_s=0 -> WAIT_LOCK (no retry counted, cnt cleared); after LOCK_STABLE consecutive cycles of lock_s=1 -> EN0.
REQ-019 EN0/EN1/EN2: pll_enclk = 001/011/111; each state lasts EN_GAP cycles; EN2 -> RUN.
REQ-020 RUN: pll_enclk=111, sys_rst=0, ready=1; retry_cnt clears on entry to RUN.
REQ-021 In any state other than RUN: sys_rst=1 and ready=0; in RST, WAIT_LOCK, STABLE and FAIL: pll_enclk=000.
REQ-022 lock_s=0 in EN0, EN1, EN2 or RUN -> RST on the next edge, with pll_enclk=000, sys_rst=1, ready=0 on that same edge; sets sticky lock_lost=1.
REQ-023 FAIL: pll_reset=1, pll_enclk=000, sys_rst=1, fail=1; exit only via reset.
REQ-024 retry_cnt SHALL saturate at MAX_RETRY and never wrap.
REQ-025 Counter width SHALL be $clog2 of the largest parameter; comparisons are exact, with no off-by-one drift.

Reset
REQ-026 reset=1 SHALL asynchronously force: state RST, cnt=0, sync flops=0, pll_reset=1, pll_enclk=000, sys_rst=1, ready=0, fail=0, retry_cnt=0, lock_lost=0.
REQ-027 Reset asserted mid-sequence (any state, including FAIL) SHALL give the REQ-026 values immediately; the sequence restarts from RST after release.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, EN_GAP=2, MAX_RETRY=2)
REQ-028 Nominal: release reset, lock rises 10 cycles later and stays high -> pll_reset high exactly 4 cycles; enclk0, enclk1, enclk2 rise 10, 12 and 14 edges after lock is first sampled; sys_rst falls and ready rises at edge 16.
REQ-029 Lock glitch: lock high for 5 cycles, low for 1, then high -> STABLE restarts; ready is delayed by the extra cycles; retry_cnt stays 0.
REQ-030 Timeout/fail: lock never asserts -> three WAIT_LOCK windows of 32 cycles, retry_cnt goes 1 then 2, then fail=1 with pll_reset held high and ready=0 indefinitely.
REQ-031 Loss in RUN: drop lock while ready=1 -> 2 edges later pll_enclk=000, sys_rst=1, lock_lost=1, pll_reset high for 4 cycles; relock reaches RUN again with lock_lost still 1.
REQ-032 Reset during EN1: assert reset -> outputs take REQ-026 values asynchronously before the next edge; full sequence repeats after release.

Source files
------------

// File: rtl/pll_rst_seq.sv
// pll_rst_seq
// Brings a PLL out of reset and hands a clean, glitch-free set of clock
// enables and a synchronous-domain reset to the logic clocked by the PLL.
// Sequence: hold the PLL in reset, wait for lock (retrying on timeout),
// insist on a stable lock period, then open enclk0/1/2 one step at a time
// and finally release sys_rst.
//
// Ports
//   clkin      reference clock (same net as the PLL input), the only clock
//   reset      asynchronous active-high reset
//   pll_lock   PLL lock indication, asynchronous to clkin
//   pll_reset  PLL reset input
//   pll_enclk  PLL output enables, bit n drives enclkn
//   sys_rst    active-high reset for the PLL-clocked logic
//   ready      high while the sequencer is in RUN
//   fail       high once lock retries are exhausted (cleared by reset only)
//   retry_cnt  number of lock timeouts seen since the last RUN
//   lock_lost  sticky flag: lock dropped after the enables were opened
module pll_rst_seq #(
   parameter int RST_CYCLES   = 64,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int LOCK_STABLE  = 256,
   parameter int EN_GAP       = 16,
   parameter int MAX_RETRY    = 7
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [2:0] pll_enclk,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic [2:0] retry_cnt,
   output logic       lock_lost
);

   localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD  = (LOCK_STABLE > EN_GAP) ? LOCK_STABLE : EN_GAP;
   localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

   // Terminal counts: each state's last cycle is when cnt equals its length minus one.
   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(EN_GAP - 1);
   localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRY);

   typedef enum logic [2:0] {
      RST,
      WAIT_LOCK,
      STABLE,
      EN0,
      EN1,
      EN2,
      RUN,
      FAIL
   } seqState_t;

   seqState_t        state;
   seqState_t        nextState;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       nextRetry;
   logic [2:0]       nextEnclk;
   logic             lossEvent;
   logic             lockMeta;
   logic             lockS;

   // Two-flop synchronizer for the PLL lock. Everything downstream looks only
   // at lockS so the FSM never sees a metastable or half-sampled lock.
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         lockMeta <= 1'b0;
         lockS    <= 1'b0;
      end else begin
         lockMeta <= pll_lock;
         lockS    <= lockMeta;
      end
   end

   // Next-state and next-retry decode. Losing lock once the enables are open
   // sends us straight back to RST and flags the loss; a lock drop while only
   // qualifying (STABLE) just goes back to waiting without burning a retry.
   // The retry counter never exceeds MAX_RETRY because reaching it diverts to FAIL.
   always_comb begin
      nextState = state;
      nextRetry = retry_cnt;
      lossEvent = 1'b0;
      unique case (state)
         RST: begin
            if (cnt == RST_LAST) nextState = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lockS) begin
               nextState = STABLE;
            end else if (cnt == TIMEOUT_LAST) begin
               if (retry_cnt >= RETRY_MAX) begin
                  nextState = FAIL;
               end else begin
                  nextState = RST;
                  nextRetry = retry_cnt + 3'd1;
               end
            end
         end
         STABLE: begin
            if (!lockS)                    nextState = WAIT_LOCK;
            else if (cnt == STABLE_LAST)   nextState = EN0;
         end
         EN0, EN1, EN2: begin
            if (!lockS) begin
               nextState = RST;
               lossEvent = 1'b1;
            end else if (cnt == GAP_LAST) begin
               if (state == EN0)      nextState = EN1;
               else if (state == EN1) nextState = EN2;
               else                   nextState = RUN;
            end
         end
         RUN: begin
            if (!lockS) begin
               nextState = RST;
               lossEvent = 1'b1;
            end
         end
         FAIL: begin
            nextState = FAIL;
         end
         default: begin
            nextState = RST;
         end
      endcase
      if (nextState == RUN) nextRetry = 3'd0;
   end

   // Enable pattern for the state we are about to enter, so the registered
   // enables change on the same edge as the state.
   always_comb begin
      nextEnclk = 3'b000;
      case (nextState)
         EN0:      nextEnclk = 3'b001;
         EN1:      nextEnclk = 3'b011;
         EN2, RUN: nextEnclk = 3'b111;
         default:  nextEnclk = 3'b000;
      endcase
   end

   // State, shared cycle counter and all registered outputs. The counter
   // restarts on every state change; outputs are decoded from nextState so
   // nothing lags the state by a cycle.
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state     <= RST;
         cnt       <= '0;
         pll_reset <= 1'b1;
         pll_enclk <= 3'b000;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         fail      <= 1'b0;
         retry_cnt <= 3'd0;
         lock_lost <= 1'b0;
      end else begin
         state     <= nextState;
         cnt       <= (nextState != state) ? '0 : cnt + CNT_W'(1);
         pll_reset <= (nextState == RST) || (nextState == FAIL);
         pll_enclk <= nextEnclk;
         sys_rst   <= (nextState != RUN);
         ready     <= (nextState == RUN);
         fail      <= (nextState == FAIL);
         retry_cnt <= nextRetry;
         lock_lost <= lock_lost | lossEvent;
      end
   end

endmodule
